// File: rtl/msx_slot_pkg.sv
// Shared types and constants for the MSX slot bus initiator.
// Optional wait-state support is enabled by defining MSX_SLOT_MASTER_WAIT_EN.
package msx_slot_pkg;

  localparam int HALF_T_CLKS_DEF = 3;
  localparam int HALVES_PER_T    = 2;

  // ST_ARM holds an accepted request until the next T-state boundary.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_T1H,
    ST_T1L,
    ST_T2H,
    ST_T2L,
    ST_TWH,
    ST_TWL,
    ST_T3H,
    ST_T3L
  } slot_state_e;

  function automatic int phase_width(input int half_t_clks);
    return (HALVES_PER_T * half_t_clks > 2) ? $clog2(HALVES_PER_T * half_t_clks) : 1;
  endfunction

endpackage

// File: rtl/msx_slot_phase_gen.sv
// Free-running T-state phase counter for the slot initiator.
// half_t_tick marks the last clk of each half-T; t1_start marks the last clk of a T-state.
module msx_slot_phase_gen
  import msx_slot_pkg::*;
#(
  parameter int HALF_T_CLKS = HALF_T_CLKS_DEF
) (
  input  logic clk,
  input  logic nreset,
  output logic half_t_tick,
  output logic t1_start
);

  localparam int PW     = phase_width(HALF_T_CLKS);
  localparam int PERIOD = HALVES_PER_T * HALF_T_CLKS;
  localparam logic [PW-1:0] CNT_MID  = PW'(HALF_T_CLKS - 1);
  localparam logic [PW-1:0] CNT_LAST = PW'(PERIOD - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign half_t_tick = (cnt_q == CNT_MID) || (cnt_q == CNT_LAST);
  assign t1_start    = (cnt_q == CNT_LAST);

endmodule

// File: rtl/msx_slot_master.sv
// MSX slot bus initiator: single-word requests become Z80-timed memory cycles.
// Define MSX_SLOT_MASTER_WAIT_EN to add the slot_nwait input and TW wait states.
module msx_slot_master
  import msx_slot_pkg::*;
#(
  parameter int HALF_T_CLKS = HALF_T_CLKS_DEF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_sltsl,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic [15:0] slot_a,
  output logic [7:0]  slot_d_out,
  output logic        slot_d_oe,
  input  logic [7:0]  slot_d_in,
  output logic        slot_nsltsl,
  output logic        slot_nmerq,
  output logic        slot_nrd,
  output logic        slot_nwr
`ifdef MSX_SLOT_MASTER_WAIT_EN
  ,input  logic       slot_nwait
`endif
);

  logic half_t_tick, t1_start;

  msx_slot_phase_gen #(.HALF_T_CLKS(HALF_T_CLKS)) u_phase (
    .clk        (clk),
    .nreset     (nreset),
    .half_t_tick(half_t_tick),
    .t1_start   (t1_start)
  );

  logic wait_hold;

`ifdef MSX_SLOT_MASTER_WAIT_EN
  logic nwait_s1_q, nwait_s2_q;
  logic nwait_s1_d, nwait_s2_d;

  always_comb begin
    nwait_s1_d = slot_nwait;
    nwait_s2_d = nwait_s1_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nwait_s1_q <= 1'b1;
      nwait_s2_q <= 1'b1;
    end else begin
      nwait_s1_q <= nwait_s1_d;
      nwait_s2_q <= nwait_s2_d;
    end
  end

  assign wait_hold = ~nwait_s2_q;
`else
  assign wait_hold = 1'b0;
`endif

  slot_state_e state_q, state_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_rdata_q, resp_rdata_d;
  logic [15:0] slot_a_q, slot_a_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        nsltsl_q, nsltsl_d;
  logic        nmerq_q, nmerq_d;
  logic        nrd_q, nrd_d;
  logic        nwr_q, nwr_d;
  logic        lat_write_q, lat_write_d;
  logic [15:0] lat_addr_q, lat_addr_d;
  logic [7:0]  lat_wdata_q, lat_wdata_d;
  logic        lat_sltsl_q, lat_sltsl_d;

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    slot_a_d     = slot_a_q;
    d_out_d      = d_out_q;
    d_oe_d       = d_oe_q;
    nsltsl_d     = nsltsl_q;
    nmerq_d      = nmerq_q;
    nrd_d        = nrd_q;
    nwr_d        = nwr_q;
    lat_write_d  = lat_write_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_sltsl_d  = lat_sltsl_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d     = ST_ARM;
          lat_write_d = req_write;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          lat_sltsl_d = req_sltsl;
        end
      end
      ST_ARM: begin
        if (t1_start) begin
          state_d  = ST_T1H;
          slot_a_d = lat_addr_q;
        end
      end
      ST_T1H: begin
        if (half_t_tick) begin
          state_d  = ST_T1L;
          nmerq_d  = 1'b0;
          nsltsl_d = ~lat_sltsl_q;
          if (lat_write_q) begin
            d_out_d = lat_wdata_q;
            d_oe_d  = 1'b1;
          end else begin
            nrd_d = 1'b0;
          end
        end
      end
      ST_T1L: if (half_t_tick) state_d = ST_T2H;
      ST_T2H: begin
        if (half_t_tick) begin
          state_d = ST_T2L;
          if (lat_write_q) nwr_d = 1'b0;
        end
      end
      // Wait sampling happens on the last clk of T2L and of every TWL.
      ST_T2L, ST_TWL: if (half_t_tick) state_d = wait_hold ? ST_TWH : ST_T3H;
      ST_TWH: if (half_t_tick) state_d = ST_TWL;
      ST_T3H: begin
        if (half_t_tick) begin
          state_d      = ST_T3L;
          nmerq_d      = 1'b1;
          nsltsl_d     = 1'b1;
          nrd_d        = 1'b1;
          nwr_d        = 1'b1;
          resp_valid_d = 1'b1;
          resp_rdata_d = lat_write_q ? 8'h00 : slot_d_in;
        end
      end
      ST_T3L: begin
        if (half_t_tick) begin
          state_d = ST_IDLE;
          d_oe_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 8'h00;
      slot_a_q     <= 16'h0000;
      d_out_q      <= 8'h00;
      d_oe_q       <= 1'b0;
      nsltsl_q     <= 1'b1;
      nmerq_q      <= 1'b1;
      nrd_q        <= 1'b1;
      nwr_q        <= 1'b1;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= 16'h0000;
      lat_wdata_q  <= 8'h00;
      lat_sltsl_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      slot_a_q     <= slot_a_d;
      d_out_q      <= d_out_d;
      d_oe_q       <= d_oe_d;
      nsltsl_q     <= nsltsl_d;
      nmerq_q      <= nmerq_d;
      nrd_q        <= nrd_d;
      nwr_q        <= nwr_d;
      lat_write_q  <= lat_write_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_sltsl_q  <= lat_sltsl_d;
    end
  end

  assign req_ready   = ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign slot_a      = slot_a_q;
  assign slot_d_out  = d_out_q;
  assign slot_d_oe   = d_oe_q;
  assign slot_nsltsl = nsltsl_q;
  assign slot_nmerq  = nmerq_q;
  assign slot_nrd    = nrd_q;
  assign slot_nwr    = nwr_q;

endmodule

// File: tb/tb_msx_slot_master.sv
// Directed bench for msx_slot_master with a response/bus scoreboard.
// Wait-state steps are compiled in when MSX_SLOT_MASTER_WAIT_EN is defined.
module tb_msx_slot_master;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        req_sltsl = 1'b0;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic [15:0] slot_a;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe;
  logic [7:0]  slot_d_in;
  logic        slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr;
  logic        slot_nwait = 1'b1;
  logic [7:0]  rsp_byte = 8'h00;

  always #5 clk = ~clk;

  // Responder drives the bus only while the read strobe is low.
  assign slot_d_in = slot_nrd ? 8'hFF : rsp_byte;

  msx_slot_master dut (
    .clk        (clk),
    .nreset     (nreset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_sltsl  (req_sltsl),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .slot_a     (slot_a),
    .slot_d_out (slot_d_out),
    .slot_d_oe  (slot_d_oe),
    .slot_d_in  (slot_d_in),
    .slot_nsltsl(slot_nsltsl),
    .slot_nmerq (slot_nmerq),
    .slot_nrd   (slot_nrd),
    .slot_nwr   (slot_nwr)
`ifdef MSX_SLOT_MASTER_WAIT_EN
    ,.slot_nwait(slot_nwait)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        write;
    logic        sltsl;
    int          ext;
  } exp_t;

  exp_t       exp_bus[$];
  logic [7:0] exp_rd[$];

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int cyc = 0;
  int last_fall = -1000;
  int last_gap = 0;
  bit drop = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  int          merq_w = 0, sl_w = 0, rd_w = 0, wr_w = 0;
  logic        p_merq = 1'b1, p_nwr = 1'b1;
  logic [15:0] cap_a = 16'h0;
  logic [7:0]  cap_d = 8'h0;
  logic        cap_oe = 1'b0;

  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cnt++;
      if (exp_rd.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
      else                    check("resp_rdata", {24'h0, resp_rdata}, {24'h0, exp_rd.pop_front()});
    end
    if (!slot_nmerq) begin
      if (p_merq) begin
        cap_a     = slot_a;
        last_gap  = cyc - last_fall;
        last_fall = cyc;
      end
      merq_w++;
    end
    if (!slot_nsltsl) sl_w++;
    if (!slot_nrd)    rd_w++;
    if (!slot_nwr) begin
      if (p_nwr) begin
        cap_d  = slot_d_out;
        cap_oe = slot_d_oe;
      end
      wr_w++;
    end
    if (slot_nmerq && !p_merq) begin
      if (!drop) begin
        if (exp_bus.size() == 0) check("bus_unexpected", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_bus.pop_front();
          check("slot_a", {16'h0, cap_a}, {16'h0, e.addr});
          check("nmerq_width", merq_w, 12 + e.ext);
          check("nsltsl_width", sl_w, e.sltsl ? 12 + e.ext : 0);
          check("nrd_width", rd_w, e.write ? 0 : 12 + e.ext);
          check("nwr_width", wr_w, e.write ? 6 + e.ext : 0);
          if (e.write) begin
            check("d_out", {24'h0, cap_d}, {24'h0, e.wdata});
            check("d_oe", {31'h0, cap_oe}, 32'd1);
          end
        end
      end
      merq_w = 0; sl_w = 0; rd_w = 0; wr_w = 0;
    end
    p_merq = slot_nmerq;
    p_nwr  = slot_nwr;
  end

  task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic s, input logic [7:0] rdat, input int ext);
    exp_t e;
    int   n;
    req_write = w; req_addr = a; req_wdata = d; req_sltsl = s; req_valid = 1'b1;
    if (!w) rsp_byte = rdat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.addr = a; e.wdata = d; e.write = w; e.sltsl = s; e.ext = ext;
      exp_bus.push_back(e);
      exp_rd.push_back(w ? 8'h00 : rdat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("resp_timeout", {31'h0, resp_cnt >= target}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_nmerq"}, {31'h0, slot_nmerq}, 32'd1);
    check({tag, "_nsltsl"}, {31'h0, slot_nsltsl}, 32'd1);
    check({tag, "_nrd"}, {31'h0, slot_nrd}, 32'd1);
    check({tag, "_nwr"}, {31'h0, slot_nwr}, 32'd1);
    check({tag, "_d_oe"}, {31'h0, slot_d_oe}, 32'd0);
    check({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd0);
  endtask

  int saved;
  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("por");
    check("por_slot_a", {16'h0, slot_a}, 32'h0);
    check("por_rdata", {24'h0, resp_rdata}, 32'h0);
    nreset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Write with slot select
    send(1'b1, 16'h5000, 8'h2A, 1'b1, 8'h00, 0);
    req_valid = 1'b0;
    wait_resp(1);

    // Read with responder data
    send(1'b0, 16'h4000, 8'h00, 1'b1, 8'hA5, 0);
    req_valid = 1'b0;
    wait_resp(2);
    repeat (8) @(negedge clk);

    // Reset while idle: address and data registers clear too
    #2 nreset = 1'b0;
    #1;
    check_idle_outputs("idle_rst");
    check("idle_rst_slot_a", {16'h0, slot_a}, 32'h0);
    check("idle_rst_rdata", {24'h0, resp_rdata}, 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Two queued writes with valid held high
    send(1'b1, 16'h6000, 8'h11, 1'b1, 8'h00, 0);
    send(1'b1, 16'h6001, 8'h22, 1'b1, 8'h00, 0);
    req_valid = 1'b0;
    wait_resp(4);
    check("b2b_gap", last_gap, 24);

    // Read without slot select
    send(1'b0, 16'h4321, 8'h00, 1'b0, 8'h3C, 0);
    req_valid = 1'b0;
    wait_resp(5);

`ifdef MSX_SLOT_MASTER_WAIT_EN
    // One wait state: nwait low at the T2L sample, high by the TWL sample
    send(1'b0, 16'h4002, 8'h00, 1'b1, 8'h5A, 6);
    req_valid  = 1'b0;
    slot_nwait = 1'b0;
    n = 0;
    while (slot_nrd && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_nrd_fall", {31'h0, slot_nrd}, 32'd0);
    repeat (10) @(negedge clk);
    slot_nwait = 1'b1;
    wait_resp(6);
`endif

    // Reset during T2 of a read drops the transaction
    saved = resp_cnt;
    send(1'b0, 16'h4100, 8'h00, 1'b1, 8'h77, 0);
    req_valid = 1'b0;
    n = 0;
    while (slot_nrd && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_nrd_fall", {31'h0, slot_nrd}, 32'd0);
    repeat (4) @(negedge clk);
    drop = 1'b1;
    #2 nreset = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    nreset = 1'b1;
    exp_bus.delete();
    exp_rd.delete();
    repeat (30) @(negedge clk);
    check("mid_rst_no_resp", resp_cnt, saved);
    drop = 1'b0;

    // Recovery after the aborted cycle
    @(posedge clk);
    #1;
    send(1'b0, 16'h7FFF, 8'h00, 1'b1, 8'hC3, 0);
    req_valid = 1'b0;
    wait_resp(saved + 1);
    repeat (10) @(negedge clk);
    check("queues_drained", exp_bus.size() + exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
